// File: rtl/secded_128_pkg.sv
// Shared definitions for the 128-bit SECDED encoder/decoder pair.
// Codeword index k holds Hamming position k+1. The overall parity bit sits at the last index.
package secded_128_pkg;

    localparam int DATA_W = 128;
    localparam int PAR_W  = 8;
    localparam int HAM_W  = DATA_W + PAR_W;
    localparam int CODE_W = HAM_W + 1;

    typedef logic [0:DATA_W-1] data_t;
    typedef logic [0:HAM_W-1]  ham_t;
    typedef logic [0:CODE_W-1] code_t;
    typedef logic [0:PAR_W-1]  par_t;

    localparam int PAR_POS [PAR_W] = '{1, 2, 4, 8, 16, 32, 64, 128};

    typedef struct packed {
        ham_t  ham;
        code_t inj;
    } s1_t;

    function automatic logic is_parity_pos(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Positions 1 and 2 are parity, so data bit 0 starts at position 3.
    // Each later parity slot that is reached pushes the data bit up by one.
    function automatic int data_idx_to_code_idx(input int didx);
        int pos;
        pos = didx + 3;
        for (int j = 2; j < PAR_W; j++) begin
            if (pos >= PAR_POS[j]) pos = pos + 1;
        end
        return pos - 1;
    endfunction

endpackage

// File: rtl/secded_128_pgen.sv
// Hamming parity generator over a position-mapped 136-bit vector.
// Every position is XORed in, so the same block yields the syndrome when fed a received codeword.
module secded_128_pgen
    import secded_128_pkg::*;
(
    input  ham_t ham_i,
    output par_t par_o
);

    always_comb begin
        par_o = '0;
        for (int j = 0; j < PAR_W; j++) begin
            for (int p = 1; p <= HAM_W; p++) begin
                if (((p >> j) & 1) != 0) par_o[j] = par_o[j] ^ ham_i[p-1];
            end
        end
    end

endmodule

// File: rtl/secded_128_enc.sv
// Two-stage SECDED(137,128) encoder with valid/ready on both sides.
// Optional per-word error-injection mask is carried alongside the data.
module secded_128_enc #(
    parameter int DATA_W = 128,
    parameter int CODE_W = 137,
    parameter int INJ_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [0:DATA_W-1] i_data,
    input  logic [0:CODE_W-1] i_inject,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [0:CODE_W-1] o_code,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_count
);

    import secded_128_pkg::*;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ham_t        ham_map;
    ham_t        ham_full;
    par_t        par_calc;
    s1_t         s1_p1_q, s1_p1_d;
    logic        vld_p1_q, vld_p1_d;
    code_t       code_p2_q, code_p2_d;
    logic        vld_p2_q, vld_p2_d;
    logic [15:0] count_q, count_d;
    logic        s2_adv, s1_adv, accept;

    // Stage 0 -> 1: scatter data into Hamming positions, parity slots left at zero
    always_comb begin
        ham_map = '0;
        for (int d = 0; d < DATA_W; d++) begin
            ham_map[data_idx_to_code_idx(d)] = i_data[d];
        end
    end

    secded_128_pgen u_pgen (
        .ham_i (ham_map),
        .par_o (par_calc)
    );

    always_comb begin
        ham_full = ham_map;
        for (int j = 0; j < PAR_W; j++) begin
            ham_full[PAR_POS[j]-1] = par_calc[j];
        end
    end

    assign s2_adv  = enable && (!vld_p2_q || i_ready);
    assign s1_adv  = enable && vld_p1_q && s2_adv;
    assign o_ready = enable && (!vld_p1_q || s2_adv);
    assign accept  = i_valid && o_ready;

    always_comb begin
        s1_p1_d.ham = ham_full;
        s1_p1_d.inj = (INJ_EN != 0) ? i_inject : '0;

        vld_p1_d = vld_p1_q;
        if (accept)      vld_p1_d = 1'b1;
        else if (s1_adv) vld_p1_d = 1'b0;

        // Stage 1 -> 2: append overall parity, then apply the injection mask
        vld_p2_d  = vld_p2_q;
        code_p2_d = code_p2_q;
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) code_p2_d = {s1_p1_q.ham, ^s1_p1_q.ham} ^ s1_p1_q.inj;
        end

        count_d = count_q;
        if (enable && vld_p2_q && i_ready) count_d = sat_inc16(count_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            code_p2_q <= '0;
            count_q   <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            code_p2_q <= code_p2_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) s1_p1_q <= s1_p1_d;
    end

    assign o_code  = code_p2_q;
    assign o_valid = vld_p2_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_secded_128_enc.sv
// Directed bench for secded_128_enc: positional codeword model plus scoreboard, and literal vectors.
module tb_secded_128_enc;

    logic          clk = 1'b0;
    logic          reset_n, enable, i_valid, i_ready;
    logic [0:127]  i_data;
    logic [0:136]  i_inject;
    logic          o_ready, o_valid, o_ready0, o_valid0;
    logic [0:136]  o_code, o_code0;
    logic [15:0]   o_count, o_count0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [0:136] exp;
        logic [0:136] clean;
    } item_t;
    item_t       q[$];
    int unsigned mcount = 0;

    always #5 clk = ~clk;

    secded_128_enc #(.DATA_W(128), .CODE_W(137), .INJ_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .i_data(i_data),
        .i_inject(i_inject), .i_valid(i_valid), .o_ready(o_ready),
        .o_code(o_code), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count)
    );

    secded_128_enc #(.DATA_W(128), .CODE_W(137), .INJ_EN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .i_data(i_data),
        .i_inject(i_inject), .i_valid(i_valid), .o_ready(o_ready0),
        .o_code(o_code0), .o_valid(o_valid0), .i_ready(i_ready), .o_count(o_count0)
    );

    // Walk Hamming positions 1..136: non-powers-of-two take data in order,
    // parity 2^j covers every position with bit j set, last bit evens the whole word.
    function automatic logic [0:136] enc_model(input logic [0:127] d);
        logic [0:136] c;
        int           di;
        logic         par;
        c  = '0;
        di = 0;
        for (int p = 1; p <= 136; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[di];
                di++;
            end
        end
        for (int j = 0; j < 8; j++) begin
            par = 1'b0;
            for (int p = 1; p <= 136; p++) begin
                if (((p >> j) & 1) == 1) par = par ^ c[p-1];
            end
            c[(1 << j) - 1] = par;
        end
        c[136] = ^c;
        return c;
    endfunction

    task automatic check(input string name, input logic [0:136] got, input logic [0:136] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Per-cycle compare against the scoreboard; inputs are stable from posedge+1 onward.
    always @(negedge clk) begin
        bit exp_rdy;
        if (!reset_n) begin
            q.delete();
            mcount = 0;
            check_i("rst_o_valid", int'(o_valid), 0);
            check_i("rst_o_count", int'(o_count), 0);
        end else begin
            exp_rdy = enable && !(q.size() == 2 && !i_ready);
            check_i("o_ready", int'(o_ready), int'(exp_rdy));
            check_i("o_valid_vs_noinj", int'(o_valid0), int'(o_valid));
            check_i("o_count", int'(o_count), int'(mcount));
            if (q.size() == 0) begin
                check_i("o_valid_spurious", int'(o_valid), 0);
            end else begin
                if (q.size() == 2) check_i("o_valid_full", int'(o_valid), 1);
                if (o_valid) begin
                    check("o_code", o_code, q[0].exp);
                    check("o_code_noinj", o_code0, q[0].clean);
                end
            end
            if (enable && o_valid && i_ready && q.size() > 0) begin
                void'(q.pop_front());
                if (mcount < 65535) mcount++;
            end
            if (i_valid && o_ready) begin
                item_t it;
                it.clean = enc_model(i_data);
                it.exp   = it.clean ^ i_inject;
                q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:127] d, input logic [0:136] m);
        int   n;
        logic took;
        n = 0;
        i_valid  = 1'b1;
        i_data   = d;
        i_inject = m;
        do begin
            #1;
            took = o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 50);
        i_valid = 1'b0;
        check_i("send_accept", int'(took), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [0:127] d;
    logic [0:136] e, m, hold;
    logic [15:0]  hc;
    logic [0:127] words [8];
    bit           saw_block;

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_data   = '0;
        i_inject = '0;
        #2 reset_n = 1'b0;
        repeat (2) step();
        check("reset_o_code", o_code, '0);
        check_i("reset_o_valid", int'(o_valid), 0);
        check_i("reset_o_count", int'(o_count), 0);
        reset_n = 1'b1;
        #1;
        check_i("reset_o_ready", int'(o_ready), 1);

        // zero word
        send('0, '0);
        step();
        check_i("zero_valid", int'(o_valid), 1);
        check("zero_code", o_code, '0);
        step();
        check_i("zero_count", int'(o_count), 1);

        // single data bit -> positions 1,2,3 and overall parity
        d = '0; d[0] = 1'b1;
        e = '0; e[0] = 1'b1; e[1] = 1'b1; e[2] = 1'b1; e[136] = 1'b1;
        check("model_pin_bit0", enc_model(d), e);
        send(d, '0);
        step();
        check_i("bit0_valid", int'(o_valid), 1);
        check("bit0_code", o_code, e);
        step();

        // all ones
        d = '1;
        e = '1; e[7] = 1'b0; e[127] = 1'b0; e[136] = 1'b0;
        check("model_pin_ones", enc_model(d), e);
        send(d, '0);
        step();
        check("ones_code", o_code, e);
        step();

        // injection: single and double bit masks
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 137'h1000;
        send(d, m);
        step();
        check("inj1_diff", o_code ^ o_code0, m);
        check("inj1_clean", o_code0, enc_model(d));
        step();
        d = {$urandom, $urandom, $urandom, $urandom};
        m = 137'h50000;
        send(d, m);
        step();
        check("inj2_diff", o_code ^ o_code0, m);
        step();
        check_i("inj_count", int'(o_count), 5);

        // backpressure: 8 words, i_ready low for 3 cycles mid-stream
        for (int k = 0; k < 8; k++) words[k] = {4{32'h1357_0000 + 32'(k * 32'h0101_1011)}};
        saw_block = 1'b0;
        begin
            int idx, cyc;
            logic took;
            idx = 0;
            cyc = 0;
            while (idx < 8 && cyc < 100) begin
                i_ready  = !(cyc >= 3 && cyc < 6);
                i_valid  = 1'b1;
                i_data   = words[idx];
                i_inject = '0;
                #1;
                took = o_ready;
                if (!i_ready && !o_ready) saw_block = 1'b1;
                if (cyc == 3) hold = o_code;
                if (cyc == 4 || cyc == 5) check("bp_hold", o_code, hold);
                @(posedge clk);
                #1;
                if (took) idx++;
                cyc++;
            end
            i_valid = 1'b0;
            i_ready = 1'b1;
        end
        for (int k = 0; k < 20 && o_valid; k++) step();
        check_i("bp_block_seen", int'(saw_block), 1);
        check_i("bp_drained", q.size(), 0);
        check_i("bp_count", int'(o_count), 13);

        // enable=0 freezes everything mid-stream
        send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0);
        send(128'hDEAD_BEEF_0000_FFFF_A5A5_5A5A_C3C3_3C3C, '0);
        enable  = 1'b0;
        i_valid = 1'b1;
        i_data  = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        #1;
        hold = o_code;
        hc   = o_count;
        for (int k = 0; k < 4; k++) begin
            check_i("en0_ready", int'(o_ready), 0);
            step();
            check("en0_code", o_code, hold);
            check_i("en0_count", int'(o_count), int'(hc));
            check_i("en0_valid", int'(o_valid), 1);
        end
        enable = 1'b1;
        send(128'h8000_0000_0000_0000_0000_0000_0000_0001, '0);
        repeat (4) step();
        check_i("en_count", int'(o_count), 16);

        // reset with two words in flight
        send({4{32'hCAFE_F00D}}, '0);
        send({4{32'h0BAD_C0DE}}, '0);
        reset_n = 1'b0;
        #1;
        check_i("midrst_valid", int'(o_valid), 0);
        check_i("midrst_count", int'(o_count), 0);
        check("midrst_code", o_code, '0);
        step();
        reset_n = 1'b1;
        #1;
        check_i("postrst_ready", int'(o_ready), 1);
        d = '0; d[127] = 1'b1;
        e = '0; e[7] = 1'b1; e[127] = 1'b1; e[135] = 1'b1; e[136] = 1'b1;
        check("model_pin_bit127", enc_model(d), e);
        send(d, '0);
        step();
        check_i("postrst_valid", int'(o_valid), 1);
        check("postrst_code", o_code, e);
        step();
        check_i("postrst_count", int'(o_count), 1);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
